// File: rtl/motor_spi_scheduler_pkg.sv
// ------------------------------------------------------------------
// motor_spi_pkg : shared types and constants for the motor-board SPI scheduler
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package motor_spi_pkg;

  localparam int NUM_DEV_DEF    = 7;
  localparam int DATA_WIDTH_DEF = 16;

  localparam int DRV0 = 0;
  localparam int DRV1 = 1;
  localparam int DRV2 = 2;
  localparam int DRV3 = 3;
  localparam int DRV4 = 4;
  localparam int ADC0 = 5;
  localparam int ADC1 = 6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_HOLD  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  function automatic logic [NUM_DEV_DEF-1:0] onehot_to_ncs(input logic [NUM_DEV_DEF-1:0] onehot);
    return ~onehot;
  endfunction

  // A zero-length interval still occupies one cycle, so its last count is 0.
  function automatic int unsigned cnt_last(input int unsigned p);
    return (p == 0) ? 0 : p - 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned p);
    return $clog2((p == 0) ? 1 : p) + 1;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/motor_spi_scheduler_if.sv
// ------------------------------------------------------------------
// motor_spi_scheduler_if : requester and SPI-master signals of the scheduler
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface motor_spi_scheduler_if
  import motor_spi_pkg::*;
#(
  parameter int NUM_DEV    = NUM_DEV_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  localparam int IDX_W = $clog2(NUM_DEV);

  logic [NUM_DEV-1:0]            req;
  logic [NUM_DEV*DATA_WIDTH-1:0] req_data;
  logic [NUM_DEV-1:0]            ack;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          rsp_err;
  logic [IDX_W-1:0]              cur_dev;
  logic                          idle;
  logic                          m_go;
  logic [DATA_WIDTH-1:0]         m_datai;
  logic                          m_busy;
  logic                          m_done;
  logic [DATA_WIDTH-1:0]         m_datao;
  logic [NUM_DEV-1:0]            dev_ncs;

  modport master (
    input  req, req_data, m_busy, m_done, m_datao,
    output ack, rsp_data, rsp_err, cur_dev, idle, m_go, m_datai, dev_ncs
  );

  modport slave (
    output req, req_data, m_busy, m_done, m_datao,
    input  ack, rsp_data, rsp_err, cur_dev, idle, m_go, m_datai, dev_ncs
  );

endinterface

`default_nettype wire

// File: rtl/motor_spi_scheduler_rr_arbiter.sv
// ------------------------------------------------------------------
// rr_arbiter : rotating-priority encoder with last-served pointer
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int NUM_DEV = 7,
  parameter int IDX_W   = $clog2(NUM_DEV)
) (
  input  logic               clk,
  input  logic               resetb,
  input  logic [NUM_DEV-1:0] req,
  input  logic               grant_en,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  // Scan from the farthest offset down so the nearest requester after ptr wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_DEV - 1; k >= 0; k--) begin
      if (req[(int'(ptr_q) + k) % NUM_DEV]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'((int'(ptr_q) + k) % NUM_DEV);
      end
    end
  end

  assign ptr_d = (grant_idx == IDX_W'(NUM_DEV - 1)) ? '0 : grant_idx + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (!resetb) begin
      ptr_q <= '0;
    end else if (grant_en && grant_valid) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/motor_spi_scheduler.sv
// ------------------------------------------------------------------
// motor_spi_scheduler : round-robin sharing of one SPI master among motor-board devices
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module motor_spi_scheduler
  import motor_spi_pkg::*;
#(
  parameter int NUM_DEV    = NUM_DEV_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int CS_GAP     = 2,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  resetb,
  motor_spi_scheduler_if.master sif
);

  localparam int IDX_W = $clog2(NUM_DEV);
  localparam int CNT_W = int'(max_u(max_u(cnt_width(CS_SETUP), cnt_width(CS_HOLD)),
                                    max_u(cnt_width(CS_GAP), cnt_width(TIMEOUT))));
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(cnt_last(CS_SETUP));
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(cnt_last(CS_HOLD));
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(cnt_last(CS_GAP));
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(cnt_last(TIMEOUT));

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [IDX_W-1:0]      cur_dev_q;
  logic [DATA_WIDTH-1:0] datai_q;
  logic [DATA_WIDTH-1:0] rsp_q;
  logic                  err_q;
  logic [NUM_DEV-1:0]    ncs_q;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_valid;
  logic [NUM_DEV-1:0]    grant_oh;
  logic                  grant_en;
  logic                  hold_last;
  logic                  to_hit;

  rr_arbiter #(
    .NUM_DEV (NUM_DEV),
    .IDX_W   (IDX_W)
  ) u_arb (
    .clk         (clk),
    .resetb      (resetb),
    .req         (sif.req),
    .grant_en    (grant_en),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign grant_en  = (state_q == S_IDLE);
  assign grant_oh  = NUM_DEV'(1) << grant_idx;
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign hold_last = (cnt_q == HOLD_LAST);
  assign to_hit    = (cnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          state_d = S_SETUP;
          cnt_d   = '0;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_START;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_START: begin
        if (!sif.m_busy) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (sif.m_done || to_hit) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_HOLD: begin
        if (hold_last) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset is folded into ack so a transaction cut short by reset never acknowledges.
  always_comb begin
    sif.m_go    = (state_q == S_START) && !sif.m_busy;
    sif.idle    = (state_q == S_IDLE);
    sif.ack     = '0;
    sif.rsp_err = 1'b0;
    if (resetb && (state_q == S_HOLD) && hold_last) begin
      sif.ack     = NUM_DEV'(1) << cur_dev_q;
      sif.rsp_err = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      cur_dev_q <= '0;
      datai_q   <= '0;
      rsp_q     <= '0;
      err_q     <= 1'b0;
      ncs_q     <= '1;
    end else begin
      if ((state_q == S_IDLE) && grant_valid) begin
        cur_dev_q <= grant_idx;
        datai_q   <= sif.req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        ncs_q     <= NUM_DEV'(onehot_to_ncs(NUM_DEV_DEF'(grant_oh)));
        err_q     <= 1'b0;
      end
      if (state_q == S_WAIT) begin
        if (sif.m_done) begin
          rsp_q <= sif.m_datao;
        end else if (to_hit) begin
          rsp_q <= '0;
          err_q <= 1'b1;
        end
      end
      if ((state_q == S_HOLD) && hold_last) begin
        ncs_q <= '1;
      end
    end
  end

  assign sif.rsp_data = rsp_q;
  assign sif.cur_dev  = cur_dev_q;
  assign sif.m_datai  = datai_q;
  assign sif.dev_ncs  = ncs_q;

endmodule

`default_nettype wire
